regfile_mmio_param: RTL and testbench
=====================================

// Module: regfile_mmio_param
// PURPOSE
//  Parametrised processor register file; successor to the fixed 32x32, 2-read-port file.
//  Adds configurable width, depth and read-port count.
//  Adds NUM_HW hardware-sourced registers, e.g. button, screen and collision inputs, each with a valid strobe.
//  Tracks per-channel fresh/overrun status, cleared by a CPU read strobe.
//  Sits between the decode/writeback stages and the game peripherals.
// PARAMETERS
//  WIDTH    32  data width of every register
//  DEPTH    32  register count; power of two, >=8; AW = $clog2(DEPTH)
//  NUM_RD   2   number of independent read ports
//  NUM_HW   4   hardware-sourced registers, mapped at HW_BASE..HW_BASE+NUM_HW-1
//  HW_BASE  20  first hardware-mapped index; HW_BASE+NUM_HW <= DEPTH, HW_BASE >= 1
// PORTS
//  clock          in   1            single clock, rising edge
//  ctrl_reset_n   in   1            asynchronous, active-low reset
//  ctrl_we        in   1            CPU write enable
//  ctrl_wr_addr   in   AW           CPU write index
//  data_wr        in   WIDTH        CPU write data
//  rd_addr        in   NUM_RD*AW    read indices, port p at [p*AW +: AW]
//  rd_en          in   NUM_RD       read strobes; clear fresh flag of addressed hw register
//  rd_data        out  NUM_RD*WIDTH read data, port p at [p*WIDTH +: WIDTH]
//  hw_valid       in   NUM_HW       per-channel capture strobe
//  hw_data        in   NUM_HW*WIDTH per-channel data
//  hw_fresh       out  NUM_HW       captured value not yet read by CPU
//  hw_overrun     out  NUM_HW       sticky: capture arrived while fresh was still set
//  reg_tap        out  4*WIDTH      live values of regs HW_BASE-6..HW_BASE-3, for display logic
// BEHAVIOUR
//  - Reset (async assert, sync release):
//    - All registers are 0.
//    - hw_fresh = 0 and hw_overrun = 0.
//    - rd_data reflects the zeroed registers.
//  - Reg 0 reads 0 at all times; writes to it are ignored (CPU and hw).
//  - Read timing: combinational, 0-cycle latency; mux-based, no tristates.
//  - CPU write: if ctrl_we, reg[ctrl_wr_addr] <= data_wr at the clock edge.
//  - HW channel c (index HW_BASE+c): if hw_valid[c], reg <= hw_data[c] at the clock edge.
//    - If hw_valid[c] and ctrl_we target the same index in the same cycle, the hw write wins.
//    - The CPU write is dropped; no error is flagged.
//  - Fresh/overrun flags, next state per channel c:
//    - clr = any port p with rd_en[p] && rd_addr[p]==HW_BASE+c.
//    - hw_valid[c]: fresh <= 1; overrun <= overrun | (fresh & ~clr).
//    - else if clr: fresh <= 0.
//    - A CPU write to a hw index never changes fresh or overrun.
//  - Clearing overrun: a CPU write of any value to index HW_BASE+NUM_HW clears all overrun bits.
//    - This applies only when that index is < DEPTH; otherwise overrun clears only on reset.
//  - Read-port rules:
//    - Multiple ports may address the same register.
//    - Out-of-range indices cannot occur (AW exact).
//  - Reset mid-cycle: asynchronous; in-flight writes are lost.
// CONFIGURATION
//  WRITE_BYPASS_EN defined:
//    - rd_data[p] returns the value being written this cycle when the read index matches the write index and the index != 0.
//    - Value priority: hw_data over data_wr.
//    - This gives same-cycle write-through for the decode stage.
//  WRITE_BYPASS_EN undefined:
//    - rd_data returns the stored value; a new write is visible on the cycle after the edge.
// STRUCTURE
//  - Package regfile_pkg:
//    - Defaults as localparams: RF_WIDTH, RF_DEPTH, RF_HW_BASE.
//    - typedef rf_addr_t.
//    - Function rf_is_hw(addr).
//  - Sub-module regfile_hw_channel (one per NUM_HW):
//    - Holds the data register plus the fresh/overrun flags.
//    - Inputs: hw_valid, hw_data, cpu_we_hit, clr, ovr_clr.
//  - Remaining registers are a plain generate array.
//  - Read muxes are a generate loop over NUM_RD.
// TESTING
//  1. Reset, then write 0xDEADBEEF to r0 -> rd_data of r0 = 0; write 0x1234 to r5 -> r5 reads 0x1234 next cycle.
//  2. Same cycle: ctrl_we r20 = 0xAAAA and hw_valid[0] with data 0x5555 -> r20 = 0x5555, hw_fresh[0]=1.
//  3. hw_valid[1] twice with no read between -> hw_overrun[1]=1.
//     Then rd_en on r21 -> fresh[1]=0, overrun[1] stays 1.
//     Then write r24 (default) -> overrun=0.
//  4. hw_valid[2] in the same cycle as rd_en on r22 while fresh[2]=1 -> fresh[2]=1, overrun[2]=0.
//  5. With WRITE_BYPASS_EN: write 0x77 to r9, read r9 on both ports that cycle -> 0x77; without it -> old value.
//  6. Assert ctrl_reset_n=0 between clock edges during a hw_valid burst -> all regs and flags 0 immediately.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults, address type and hw-range helper for the parametrised register file.
// No logic of its own; pure declarations.
// No flow control.
package regfile_pkg;

  localparam int RF_WIDTH   = 32;
  localparam int RF_DEPTH   = 32;
  localparam int RF_NUM_RD  = 2;
  localparam int RF_NUM_HW  = 4;
  localparam int RF_HW_BASE = 20;
  localparam int RF_AW      = $clog2(RF_DEPTH);

  typedef logic [RF_AW-1:0] rf_addr_t;

  // True when addr falls inside the hardware-sourced window [base, base+num).
  function automatic logic rf_is_hw(input int addr,
                                    input int base = RF_HW_BASE,
                                    input int num  = RF_NUM_HW);
    return (addr >= base) && (addr < base + num);
  endfunction

endpackage

// File: rtl/regfile_hw_channel.sv
// One hardware-sourced register: data plus fresh/overrun status flags.
// Latency: captures on the clock edge; outputs are the registered state.
// No backpressure: every hw_valid strobe is captured, overlap is recorded as overrun.
module regfile_hw_channel
  import regfile_pkg::*;
#(
  parameter int WIDTH = RF_WIDTH
) (
  input  logic             clock,
  input  logic             ctrl_reset_n,
  input  logic             hw_valid,
  input  logic [WIDTH-1:0] hw_data,
  input  logic             cpu_we_hit,
  input  logic [WIDTH-1:0] cpu_data,
  input  logic             clr,
  input  logic             ovr_clr,
  output logic [WIDTH-1:0] data,
  output logic             fresh,
  output logic             overrun
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             fresh_q, fresh_d;
  logic             overrun_q, overrun_d;

  // Next state: hw capture beats a same-cycle CPU write; a CPU write never touches the flags.
  // A clear and a new overrun in the same cycle keep the new overrun so the event is not lost.
  always_comb begin
    data_d    = data_q;
    fresh_d   = fresh_q;
    overrun_d = ovr_clr ? 1'b0 : overrun_q;
    if (hw_valid) begin
      data_d    = hw_data;
      fresh_d   = 1'b1;
      overrun_d = overrun_d | (fresh_q & ~clr);
    end else begin
      if (cpu_we_hit) data_d = cpu_data;
      if (clr)        fresh_d = 1'b0;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      data_q    <= '0;
      fresh_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      fresh_q   <= fresh_d;
      overrun_q <= overrun_d;
    end
  end

  assign data    = data_q;
  assign fresh   = fresh_q;
  assign overrun = overrun_q;

endmodule

// File: rtl/regfile_mmio_param.sv
// Parametrised register file with CPU writes, hw-captured channels and fresh/overrun status (optional WRITE_BYPASS_EN).
// Latency: reads combinational (0 cycles); writes land at the clock edge, or same cycle with WRITE_BYPASS_EN.
// No backpressure: writes and captures always accepted; hw wins over CPU on the same index.
module regfile_mmio_param
  import regfile_pkg::*;
#(
  parameter int WIDTH   = RF_WIDTH,
  parameter int DEPTH   = RF_DEPTH,
  parameter int NUM_RD  = RF_NUM_RD,
  parameter int NUM_HW  = RF_NUM_HW,
  parameter int HW_BASE = RF_HW_BASE,
  parameter int AW      = $clog2(DEPTH)
) (
  input  logic                    clock,
  input  logic                    ctrl_reset_n,
  input  logic                    ctrl_we,
  input  logic [AW-1:0]           ctrl_wr_addr,
  input  logic [WIDTH-1:0]        data_wr,
  input  logic [NUM_RD*AW-1:0]    rd_addr,
  input  logic [NUM_RD-1:0]       rd_en,
  output logic [NUM_RD*WIDTH-1:0] rd_data,
  input  logic [NUM_HW-1:0]       hw_valid,
  input  logic [NUM_HW*WIDTH-1:0] hw_data,
  output logic [NUM_HW-1:0]       hw_fresh,
  output logic [NUM_HW-1:0]       hw_overrun,
  output logic [4*WIDTH-1:0]      reg_tap
);

  // Writing the index just past the hw window clears all overrun flags, if that index exists.
  localparam bit OVR_CLR_EN = (HW_BASE + NUM_HW) < DEPTH;
  localparam int OVR_IDX    = OVR_CLR_EN ? (HW_BASE + NUM_HW) : 0;

  logic [DEPTH-1:0][WIDTH-1:0] reg_val;
  logic [NUM_HW-1:0]           clr_vec;
  logic                        ovr_clr;

  assign ovr_clr    = OVR_CLR_EN && ctrl_we && (ctrl_wr_addr == AW'(OVR_IDX));
  assign reg_val[0] = '0;

  // Per-channel read-clear: any enabled read port addressing the channel's index.
  always_comb begin
    clr_vec = '0;
    for (int c = 0; c < NUM_HW; c++) begin
      for (int p = 0; p < NUM_RD; p++) begin
        if (rd_en[p] && (rd_addr[p*AW +: AW] == AW'(HW_BASE + c))) clr_vec[c] = 1'b1;
      end
    end
  end

  // Plain CPU-only registers; reg 0 is a constant zero and has no storage.
  for (genvar i = 1; i < DEPTH; i++) begin : g_reg
    if (!rf_is_hw(i, HW_BASE, NUM_HW)) begin : g_plain
      logic [WIDTH-1:0] reg_q, reg_d;

      // Load CPU data when this index is targeted.
      always_comb begin
        reg_d = reg_q;
        if (ctrl_we && (ctrl_wr_addr == AW'(i))) reg_d = data_wr;
      end

      // Storage with asynchronous clear.
      always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) reg_q <= '0;
        else               reg_q <= reg_d;
      end

      assign reg_val[i] = reg_q;
    end
  end

  // Hardware-sourced registers.
  for (genvar c = 0; c < NUM_HW; c++) begin : g_hw
    regfile_hw_channel #(.WIDTH(WIDTH)) u_chan (
      .clock        (clock),
      .ctrl_reset_n (ctrl_reset_n),
      .hw_valid     (hw_valid[c]),
      .hw_data      (hw_data[c*WIDTH +: WIDTH]),
      .cpu_we_hit   (ctrl_we && (ctrl_wr_addr == AW'(HW_BASE + c))),
      .cpu_data     (data_wr),
      .clr          (clr_vec[c]),
      .ovr_clr      (ovr_clr),
      .data         (reg_val[HW_BASE + c]),
      .fresh        (hw_fresh[c]),
      .overrun      (hw_overrun[c])
    );
  end

  // Independent read muxes.
  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] rd_val;

    assign addr = rd_addr[p*AW +: AW];

    // Stored value, optionally overridden by the write landing this cycle (hw data has priority).
    always_comb begin
      rd_val = reg_val[addr];
`ifdef WRITE_BYPASS_EN
      if (addr != '0) begin
        if (ctrl_we && (ctrl_wr_addr == addr)) rd_val = data_wr;
        for (int c = 0; c < NUM_HW; c++) begin
          if (hw_valid[c] && (addr == AW'(HW_BASE + c))) rd_val = hw_data[c*WIDTH +: WIDTH];
        end
      end
`endif
    end

    assign rd_data[p*WIDTH +: WIDTH] = rd_val;
  end

  // Display taps: regs HW_BASE-6 .. HW_BASE-3, lowest index in the low slice.
  for (genvar k = 0; k < 4; k++) begin : g_tap
    localparam int TI = HW_BASE - 6 + k;
    if (TI >= 0) begin : g_live
      assign reg_tap[k*WIDTH +: WIDTH] = reg_val[TI];
    end else begin : g_none
      assign reg_tap[k*WIDTH +: WIDTH] = '0;
    end
  end

endmodule

// File: tb/tb_regfile_mmio_param.sv
// Directed bench for regfile_mmio_param at default parameters (WIDTH 32, DEPTH 32, 2 read ports, hw at 20..23).
// Inputs change 1 time unit after the rising edge; outputs are sampled mid-cycle.
// Expectations for same-cycle reads follow WRITE_BYPASS_EN when it is defined.
module tb_regfile_mmio_param;

  localparam int W  = 32;
  localparam int AW = 5;

  logic              clock;
  logic              ctrl_reset_n;
  logic              ctrl_we;
  logic [AW-1:0]     ctrl_wr_addr;
  logic [W-1:0]      data_wr;
  logic [2*AW-1:0]   rd_addr;
  logic [1:0]        rd_en;
  logic [2*W-1:0]    rd_data;
  logic [3:0]        hw_valid;
  logic [4*W-1:0]    hw_data;
  logic [3:0]        hw_fresh;
  logic [3:0]        hw_overrun;
  logic [4*W-1:0]    reg_tap;

  int n_chk  = 0;
  int n_pass = 0;

  regfile_mmio_param dut (
    .clock        (clock),
    .ctrl_reset_n (ctrl_reset_n),
    .ctrl_we      (ctrl_we),
    .ctrl_wr_addr (ctrl_wr_addr),
    .data_wr      (data_wr),
    .rd_addr      (rd_addr),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .hw_valid     (hw_valid),
    .hw_data      (hw_data),
    .hw_fresh     (hw_fresh),
    .hw_overrun   (hw_overrun),
    .reg_tap      (reg_tap)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d);
    ctrl_we      = 1'b1;
    ctrl_wr_addr = a;
    data_wr      = d;
    step();
    ctrl_we      = 1'b0;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_addr = {a1, a0};
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] same_cycle_r9;
`ifdef WRITE_BYPASS_EN
    same_cycle_r9 = 32'h77;
`else
    same_cycle_r9 = 32'h10;
`endif
    ctrl_reset_n = 1'b0;
    ctrl_we      = 1'b0;
    ctrl_wr_addr = '0;
    data_wr      = '0;
    rd_addr      = '0;
    rd_en        = '0;
    hw_valid     = '0;
    hw_data      = '0;

    // Reset state
    repeat (2) step();
    set_rd(5'd0, 5'd5);
    chk("rst_rd", rd_data, 0);
    chk("rst_fresh", hw_fresh, 0);
    chk("rst_ovr", hw_overrun, 0);
    chk("rst_tap", reg_tap, 0);
    ctrl_reset_n = 1'b1;
    step();

    // r0 is hardwired, r5 takes a write
    wr(5'd0, 32'hDEADBEEF);
    set_rd(5'd0, 5'd0);
    chk("r0_p0", rd_data[W-1:0], 0);
    chk("r0_p1", rd_data[2*W-1:W], 0);
    wr(5'd5, 32'h1234);
    set_rd(5'd5, 5'd0);
    chk("r5_p0", rd_data[W-1:0], 32'h1234);

    // Display taps cover r14..r17
    wr(5'd14, 32'h0E0E0E0E);
    wr(5'd15, 32'h15);
    wr(5'd16, 32'h16);
    wr(5'd17, 32'h17);
    chk("tap", reg_tap, {32'h17, 32'h16, 32'h15, 32'h0E0E0E0E});

    // CPU and hw both target r20: hw wins
    ctrl_we = 1'b1; ctrl_wr_addr = 5'd20; data_wr = 32'hAAAA;
    hw_valid = 4'b0001; hw_data[W-1:0] = 32'h5555;
    step();
    ctrl_we = 1'b0; hw_valid = '0;
    set_rd(5'd20, 5'd20);
    chk("r20_hw_win_p0", rd_data[W-1:0], 32'h5555);
    chk("r20_hw_win_p1", rd_data[2*W-1:W], 32'h5555);
    chk("fresh0_set", hw_fresh, 4'b0001);
    // CPU write to a hw index changes data but not flags
    wr(5'd20, 32'h1111);
    chk("r20_cpu", rd_data[W-1:0], 32'h1111);
    chk("fresh0_kept", hw_fresh, 4'b0001);
    chk("ovr_none", hw_overrun, 4'b0000);

    // Two captures on channel 1 with no read between
    hw_valid = 4'b0010; hw_data[2*W-1:W] = 32'h11;
    step();
    hw_data[2*W-1:W] = 32'h22;
    step();
    hw_valid = '0;
    set_rd(5'd21, 5'd0);
    chk("r21_last", rd_data[W-1:0], 32'h22);
    chk("ovr1_set", hw_overrun, 4'b0010);
    chk("fresh01", hw_fresh, 4'b0011);
    rd_en = 2'b01;
    step();
    rd_en = '0;
    chk("fresh1_clr", hw_fresh, 4'b0001);
    chk("ovr1_sticky", hw_overrun, 4'b0010);
    wr(5'd24, 32'h0);
    chk("ovr_clr_r24", hw_overrun, 4'b0000);
    chk("fresh_after_r24", hw_fresh, 4'b0001);

    // Capture and read-clear on the same cycle while fresh
    hw_valid = 4'b0100; hw_data[3*W-1:2*W] = 32'h33;
    step();
    chk("fresh2_set", hw_fresh, 4'b0101);
    hw_data[3*W-1:2*W] = 32'h44;
    rd_addr = {5'd22, 5'd0}; rd_en = 2'b10;
    step();
    hw_valid = '0; rd_en = '0;
    set_rd(5'd0, 5'd22);
    chk("fresh2_kept", hw_fresh, 4'b0101);
    chk("ovr2_none", hw_overrun, 4'b0000);
    chk("r22_p1", rd_data[2*W-1:W], 32'h44);

    // Same-cycle write/read of r9
    wr(5'd9, 32'h10);
    ctrl_we = 1'b1; ctrl_wr_addr = 5'd9; data_wr = 32'h77;
    set_rd(5'd9, 5'd9);
    chk("r9_same_p0", rd_data[W-1:0], same_cycle_r9);
    chk("r9_same_p1", rd_data[2*W-1:W], same_cycle_r9);
    step();
    ctrl_we = 1'b0;
    chk("r9_next", rd_data, {32'h77, 32'h77});

    // Asynchronous reset in the middle of a hw_valid burst
    hw_valid = 4'b1000; hw_data[4*W-1:3*W] = 32'h66;
    step();
    hw_data[4*W-1:3*W] = 32'h67;
    step();
    chk("ovr3_set", hw_overrun, 4'b1000);
    hw_data[4*W-1:3*W] = 32'h68;
    #3;
    ctrl_reset_n = 1'b0;
    set_rd(5'd5, 5'd23);
    chk("arst_rd", rd_data, 0);
    chk("arst_fresh", hw_fresh, 0);
    chk("arst_ovr", hw_overrun, 0);
    chk("arst_tap", reg_tap, 0);
    set_rd(5'd9, 5'd20);
    chk("arst_rd2", rd_data, 0);
    hw_valid = '0;
    step();
    ctrl_reset_n = 1'b1;
    step();
    set_rd(5'd5, 5'd23);
    chk("post_rst_rd", rd_data, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
